// File: rtl/serial_rx_pkg.sv
// Shared constants for the serial receive buffer: register map, status and
// control bit positions, and the receiver state encoding.
package serial_rx_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;

    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_ERR = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/serial_rx_deserializer.sv
// 8N1 deserialiser: rxd synchroniser, framing FSM and LSB-first shift register.
// Emits a one-cycle byte_valid with the byte, or frame_err_pulse on a bad stop bit.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge
// S_START | checking the start bit at mid-bit
// S_DATA  | shifting in 8 data bits, LSB first
// S_STOP  | checking the stop bit; on a break, waiting for the line to return high
module serial_rx_deserializer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic            sync_meta, sync_rxd, rxd_prev;
    rx_state_t       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      bit_idx, idx_next;
    logic [7:0]      shift, shift_next;
    logic            brk, brk_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_rxd  <= 1'b1;
            rxd_prev  <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            brk       <= 1'b0;
        end else begin
            sync_meta <= rxd;
            sync_rxd  <= sync_meta;
            rxd_prev  <= sync_rxd;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= idx_next;
            shift     <= shift_next;
            brk       <= brk_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt + CW'(1);
        idx_next        = bit_idx;
        shift_next      = shift;
        brk_next        = brk;
        byte_valid      = 1'b0;
        frame_err_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                brk_next = 1'b0;
                if (rxd_prev && !sync_rxd) state_next = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = sync_rxd ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {sync_rxd, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = S_STOP;
                    else                 idx_next   = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (brk) begin
                    // Break: hold here so a long low line cannot look like a new start bit.
                    cnt_next = '0;
                    if (sync_rxd) begin
                        brk_next   = 1'b0;
                        state_next = S_IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (sync_rxd) begin
                        byte_valid = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_err_pulse = 1'b1;
                        brk_next        = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/serial_rx_buffer.sv
// UART receiver with a byte FIFO behind a PicoBlaze-style data/status port pair.
// ready stays high while the FIFO holds data.
module serial_rx_buffer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_LOG2    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       en,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [7:0] rx_byte;
    logic       byte_valid, frame_err_pulse;

    serial_rx_deserializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
        .clk             (clk),
        .reset           (reset),
        .rxd             (rxd),
        .rx_byte         (rx_byte),
        .byte_valid      (byte_valid),
        .frame_err_pulse (frame_err_pulse)
    );

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count, count_next;
    logic                 empty, full, pop, ctl_wr, flush, clr_err, do_push, set_ovr;
    logic                 overrun, frame_err;
    logic                 unused_ctl;

    assign unused_ctl = ^data_in[7:2];

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_LOG2 + 1)'(DEPTH));
    assign pop     = en & ~wr & (addr == ADDR_DATA) & ~empty;
    assign ctl_wr  = en & wr & (addr == ADDR_STATUS);
    assign flush   = ctl_wr & data_in[CTL_FLUSH];
    assign clr_err = ctl_wr & data_in[CTL_CLR_ERR];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push = byte_valid & (~full | pop) & ~flush;
    assign set_ovr = byte_valid & full & ~pop & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            ready     <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            ready     <= (count_next != '0);
            overrun   <= (overrun & ~clr_err) | set_ovr;
            frame_err <= (frame_err & ~clr_err) | frame_err_pulse;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (en && !wr) begin
            if (addr == ADDR_DATA) begin
                if (!empty) data_out = mem[rd_ptr];
            end else begin
                data_out[ST_NOT_EMPTY] = ~empty;
                data_out[ST_OVERRUN]   = overrun;
                data_out[ST_FRAME_ERR] = frame_err;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Scenario bench for serial_rx_buffer with an expected-byte queue and flag model.
module tb_serial_rx_buffer;
    import serial_rx_pkg::*;

    localparam int CPB   = 8;
    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;

    logic       clk = 1'b0;
    logic       reset, rxd, en, wr, addr;
    logic [7:0] data_in, data_out;
    logic       ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;

    serial_rx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_status();
        return {5'b0, m_ferr, m_ovr, (exp_q.size() != 0)};
    endfunction

    function automatic logic [7:0] exp_pop();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q.pop_front();
    endfunction

    // Drives one 8N1 frame; with upd=1 the expected queue and flags are updated.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic upd);
        if (upd) begin
            if (!stop_bit)               m_ferr = 1'b1;
            else if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                          m_ovr = 1'b1;
        end
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stop_bit;
        repeat (CPB) tick();
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        en = 1'b1; wr = 1'b0; addr = a;
        #2 d = data_out;
        tick();
        en = 1'b0;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] v);
        en = 1'b1; wr = 1'b1; addr = a; data_in = v;
        #2;
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL write_data_out: got %02h expected 00", data_out);
        end
        tick();
        en = 1'b0; wr = 1'b0; data_in = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; rxd = 1'b1; en = 1'b0; wr = 1'b0; addr = 1'b0; data_in = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %02h expected 00", data_out); end
        checks++;
        if (dut.u_deser.state !== S_IDLE) begin
            failures++; $display("FAIL reset_state: got %0d expected %0d", dut.u_deser.state, S_IDLE);
        end
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_status: got %02h expected 00", d); end
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_empty_read: got %02h expected 00", d); end
    endtask

    task automatic test_single();
        logic [7:0] d, e;
        logic hit;
        hit = 1'b0;
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 200 && !hit; i++) begin
                    tick();
                    if (dut.u_deser.byte_valid === 1'b1) hit = 1'b1;
                end
                checks++;
                if (!hit) begin
                    failures++; $display("FAIL single_push_timeout: got no push expected push");
                end else begin
                    checks++;
                    if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_early: got %b expected 0", ready); end
                    tick();
                    checks++;
                    if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_rise: got %b expected 1", ready); end
                end
            end
        join
        rxd = 1'b1;
        e = exp_pop();
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL single_read: got %02h expected %02h", d, e); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_fall: got %b expected 0", ready); end
        e = exp_pop();
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL single_second_read: got %02h expected %02h", d, e); end
    endtask

    task automatic test_overrun();
        logic [7:0] d, e;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
        rxd = 1'b1;
        repeat (4) tick();
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ovr_status_full: got %02h expected %02h", d, e); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_pop();
            bus_read(ADDR_DATA, d);
            checks++;
            if (d !== e) begin failures++; $display("FAIL ovr_read%0d: got %02h expected %02h", i, d, e); end
        end
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ovr_status_empty: got %02h expected %02h", d, e); end
        bus_write(ADDR_STATUS, 8'h02);
        m_ovr = 1'b0; m_ferr = 1'b0;
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ovr_status_cleared: got %02h expected %02h", d, e); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d, e;
        send_byte(8'h3C, 1'b0, 1'b1);
        repeat (3 * CPB) tick();
        rxd = 1'b1;
        repeat (CPB) tick();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL ferr_ready: got %b expected 0", ready); end
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ferr_status: got %02h expected %02h", d, e); end
        send_byte(8'h11, 1'b1, 1'b1);
        rxd = 1'b1;
        repeat (2) tick();
        e = exp_pop();
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ferr_next_frame: got %02h expected %02h", d, e); end
        bus_write(ADDR_STATUS, 8'h02);
        m_ferr = 1'b0; m_ovr = 1'b0;
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL ferr_cleared: got %02h expected %02h", d, e); end
    endtask

    task automatic test_glitch();
        logic [7:0] d, e;
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (3 * CPB) tick();
        checks++;
        if (dut.u_deser.state !== S_IDLE) begin
            failures++; $display("FAIL glitch_state: got %0d expected %0d", dut.u_deser.state, S_IDLE);
        end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL glitch_ready: got %b expected 0", ready); end
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL glitch_status: got %02h expected %02h", d, e); end
    endtask

    task automatic test_full_simul();
        logic [7:0] d, e, seen;
        logic hit;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b1, 1'b1);
        hit = 1'b0;
        seen = 8'h00;
        fork
            send_byte(8'hC3, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 200 && !hit; i++) begin
                    tick();
                    if (dut.u_deser.byte_valid === 1'b1) begin
                        hit = 1'b1;
                        bus_read(ADDR_DATA, seen);
                    end
                end
            end
        join
        rxd = 1'b1;
        checks++;
        if (!hit) begin
            failures++; $display("FAIL simul_push_timeout: got no push expected push");
        end else begin
            e = exp_pop();
            exp_q.push_back(8'hC3);
            checks++;
            if (seen !== e) begin failures++; $display("FAIL simul_read: got %02h expected %02h", seen, e); end
        end
        repeat (2) tick();
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL simul_status: got %02h expected %02h", d, e); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_pop();
            bus_read(ADDR_DATA, d);
            checks++;
            if (d !== e) begin failures++; $display("FAIL simul_drain%0d: got %02h expected %02h", i, d, e); end
        end
        send_byte(8'h77, 1'b1, 1'b1);
        send_byte(8'h88, 1'b1, 1'b1);
        rxd = 1'b1;
        repeat (2) tick();
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL flush_pre_ready: got %b expected 1", ready); end
        bus_write(ADDR_STATUS, 8'h01);
        exp_q.delete();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0", ready); end
        e = exp_pop();
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL flush_read: got %02h expected %02h", d, e); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d, e;
        rxd = 1'b0;
        repeat (CPB) tick();
        rxd = 1'b1;
        repeat (12) tick();
        checks++;
        if (dut.u_deser.state !== S_DATA) begin
            failures++; $display("FAIL midreset_in_data: got %0d expected %0d", dut.u_deser.state, S_DATA);
        end
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0;
        checks++;
        if (dut.u_deser.state !== S_IDLE) begin
            failures++; $display("FAIL midreset_state: got %0d expected %0d", dut.u_deser.state, S_IDLE);
        end
        repeat (8 * CPB) tick();
        send_byte(8'h5A, 1'b1, 1'b1);
        rxd = 1'b1;
        repeat (2) tick();
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL midreset_status: got %02h expected %02h", d, e); end
        e = exp_pop();
        bus_read(ADDR_DATA, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL midreset_read: got %02h expected %02h", d, e); end
        e = exp_status();
        bus_read(ADDR_STATUS, d);
        checks++;
        if (d !== e) begin failures++; $display("FAIL midreset_status_after: got %02h expected %02h", d, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_full_simul();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
